// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch unit: opcodes, FSM state encoding, word width.
package pc_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC candidates: pc+4, J/JAL target, branch target, predict decision.
// Backward BEQ/BNE prediction is only generated when STATIC_PREDICT_EN is defined.
module next_pc_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  branch_target,
    output logic               is_jump,
    output logic               pred_br
);

    logic [5:0] opcode;

    always_comb begin
        opcode        = instr[31:26];
        pc_plus4      = pc + ADDR_W'(4);
        // Region bits above 27 come from pc+4; the low 28 bits from the index.
        jump_target        = pc_plus4;
        jump_target[27:0]  = {instr[25:0], 2'b00};
        branch_target = pc_plus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
        is_jump       = (opcode == OP_J) || (opcode == OP_JAL);
`ifdef STATIC_PREDICT_EN
        pred_br       = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && instr[15];
`else
        pred_br       = 1'b0;
`endif
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with stall hold, pending-redirect latch and halt/restart.
// Static backward-branch prediction is enabled by defining STATIC_PREDICT_EN.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               pred_taken,
    output logic               halted,
    output logic               misalign_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pc_valid_q, pc_valid_d;
    logic              pred_q, pred_d;
    logic              mis_q, mis_d;

    logic [ADDR_W-1:0] jump_target, branch_target, tgt;
    logic              is_jump, pred_br, apply;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc            (pc_q),
        .instr         (instr),
        .pc_plus4      (pc_plus4),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .is_jump       (is_jump),
        .pred_br       (pred_br)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        pred_d  = pred_q;
        mis_d   = 1'b0;
        apply   = 1'b0;
        tgt     = redirect_pc;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid && !stall) begin
                    apply = 1'b1;
                end else if (redirect_valid) begin
                    pend_d  = redirect_pc;
                    state_d = ST_HOLD;
                end else if (!stall) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (instr_valid && is_jump) begin
                        pc_d   = jump_target;
                        pred_d = 1'b0;
                    end else if (instr_valid && pred_br) begin
                        pc_d   = branch_target;
                        pred_d = 1'b1;
                    end else begin
                        pc_d   = pc_plus4;
                        pred_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                // Newest redirect wins, both while stalled and on the release cycle.
                if (stall) begin
                    if (redirect_valid) pend_d = redirect_pc;
                end else begin
                    apply   = 1'b1;
                    if (!redirect_valid) tgt = pend_q;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    apply   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (apply) begin
            pc_d   = {tgt[ADDR_W-1:2], 2'b00};
            pred_d = 1'b0;
            mis_d  = |tgt[1:0];
        end
        pc_valid_d = (state_d != ST_HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC;
            pend_q     <= '0;
            pc_valid_q <= 1'b0;
            pred_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pc_valid_q <= pc_valid_d;
            pred_q     <= pred_d;
            mis_q      <= mis_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign pred_taken   = pred_q;
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural next-PC model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n, stall, instr_valid, redirect_valid, halt_req;
    logic [31:0] instr, redirect_pc;
    logic [31:0] pc, pc_plus4;
    logic        pc_valid, pred_taken, halted, misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc, m_pend;
    bit          m_hold, m_halt, m_valid, m_mis, m_pred;

    pc_fetch_unit #(.ADDR_W(32), .RESET_VEC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .instr(instr),
        .instr_valid(instr_valid), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .pc(pc),
        .pc_valid(pc_valid), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_hold = 0; m_halt = 0;
        m_valid = 0; m_mis = 0; m_pred = 0;
    endtask

    // Advance one clock: model computes next state from the current inputs, then the edge.
    task automatic tick();
        logic [31:0] p4, t;
        logic [5:0]  op;
        bit          taken_pred, do_apply;
        p4 = m_pc + 32'd4;
        op = instr[31:26];
        taken_pred = 0;
`ifdef STATIC_PREDICT_EN
        taken_pred = (op == 6'h04 || op == 6'h05) && instr[15];
`endif
        do_apply = 0;
        t = redirect_pc;
        m_mis = 0;
        if (m_halt) begin
            if (redirect_valid) begin do_apply = 1; m_halt = 0; end
        end else if (m_hold) begin
            if (stall) begin
                if (redirect_valid) m_pend = redirect_pc;
            end else begin
                if (!redirect_valid) t = m_pend;
                do_apply = 1; m_hold = 0;
            end
        end else if (redirect_valid && !stall) begin
            do_apply = 1;
        end else if (redirect_valid) begin
            m_pend = redirect_pc; m_hold = 1;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (halt_req) begin
            m_halt = 1;
        end else if (instr_valid && (op == 6'h02 || op == 6'h03)) begin
            m_pc = (p4 & 32'hF000_0000) | {4'h0, instr[25:0], 2'b00};
            m_pred = 0;
        end else if (instr_valid && taken_pred) begin
            m_pc = p4 + 32'($signed(instr[15:0]) * 4);
            m_pred = 1;
        end else begin
            m_pc = p4; m_pred = 0;
        end
        if (do_apply) begin
            m_pc = t & 32'hFFFF_FFFC; m_mis = (t[1:0] != 2'b00); m_pred = 0;
        end
        @(posedge clk); #1;
        m_valid = !m_halt;
    endtask

    task automatic test_reset();
        reset_n = 0; stall = 0; instr = 32'h0; instr_valid = 1;
        redirect_valid = 0; redirect_pc = 32'h0; halt_req = 0;
        #12;
        n_checks++;
        if ({pc, pc_valid, halted, pred_taken, misalign_err} !== {32'h0, 4'b0000})
            $display("FAIL reset_state pc=%h valid=%b halted=%b pred=%b mis=%b", pc, pc_valid, halted, pred_taken, misalign_err);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        n_checks++;
        if ({pc, pc_valid} !== {32'h0, 1'b0})
            $display("FAIL reset_release pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({pc, pc_valid} !== {32'(4 * i), 1'b1})
                $display("FAIL reset_seq[%0d] pc=%h valid=%b exp pc=%h valid=1", i, pc, pc_valid, 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        logic [5:0] ops[2];
        ops[0] = 6'h02; ops[1] = 6'h03;
        for (int k = 0; k < 2; k++) begin
            redirect_valid = 1; redirect_pc = 32'h0040_0010; tick();
            redirect_valid = 0;
            instr = {ops[k], 26'h010_0000};
            n_checks++;
            if (pc_plus4 !== 32'h0040_0014)
                $display("FAIL jump_link[%0d] pc_plus4=%h exp=00400014", k, pc_plus4);
            else n_pass++;
            tick();
            n_checks++;
            if (pc !== 32'h0040_0000)
                $display("FAIL jump_target[%0d] pc=%h exp=00400000", k, pc);
            else n_pass++;
        end
        instr = 32'h0;
    endtask

    task automatic test_stall_redirect();
        logic [31:0] held;
        held = pc;
        stall = 1; redirect_valid = 1; redirect_pc = 32'h1000;
        tick();
        redirect_valid = 0;
        for (int i = 0; i < 3; i++) begin
            halt_req = (i == 1);
            n_checks++;
            if (pc !== held) $display("FAIL stall_hold[%0d] pc=%h exp=%h", i, pc, held);
            else n_pass++;
            if (i < 2) tick();
        end
        halt_req = 0; stall = 0;
        tick();
        n_checks++;
        if ({pc, halted} !== {32'h1000, 1'b0})
            $display("FAIL stall_release pc=%h halted=%b exp pc=00001000 halted=0", pc, halted);
        else n_pass++;
    endtask

    task automatic test_halt();
        redirect_valid = 1; redirect_pc = 32'h20; tick();
        redirect_valid = 0; halt_req = 1; tick();
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({halted, pc_valid, pc} !== {2'b10, 32'h20})
                $display("FAIL halt_hold[%0d] halted=%b valid=%b pc=%h exp 1/0/00000020", i, halted, pc_valid, pc);
            else n_pass++;
            tick();
        end
        redirect_valid = 1; redirect_pc = 32'h200; tick();
        redirect_valid = 0;
        n_checks++;
        if ({halted, pc_valid, pc} !== {2'b01, 32'h200})
            $display("FAIL halt_exit halted=%b valid=%b pc=%h exp 0/1/00000200", halted, pc_valid, pc);
        else n_pass++;
    endtask

    task automatic test_predict();
        logic [31:0] exp_back;
        logic        exp_pred;
`ifdef STATIC_PREDICT_EN
        exp_back = 32'hF4;  exp_pred = 1;
`else
        exp_back = 32'h104; exp_pred = 0;
`endif
        redirect_valid = 1; redirect_pc = 32'h100; tick();
        redirect_valid = 0; instr = {6'h04, 5'd1, 5'd2, 16'hFFFC}; tick();
        n_checks++;
        if ({pc, pred_taken} !== {exp_back, exp_pred})
            $display("FAIL predict_back pc=%h pred=%b exp pc=%h pred=%b", pc, pred_taken, exp_back, exp_pred);
        else n_pass++;
        redirect_valid = 1; redirect_pc = 32'h100; tick();
        redirect_valid = 0; instr = {6'h04, 5'd1, 5'd2, 16'h0004}; tick();
        n_checks++;
        if ({pc, pred_taken} !== {32'h104, 1'b0})
            $display("FAIL predict_fwd pc=%h pred=%b exp pc=00000104 pred=0", pc, pred_taken);
        else n_pass++;
        instr = 32'h0;
    endtask

    task automatic test_wrap_misalign();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect_valid = 0;
        n_checks++;
        if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 pc_plus4=%h exp=00000000", pc_plus4);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 32'h0) $display("FAIL wrap_pc pc=%h exp=00000000", pc);
        else n_pass++;
        redirect_valid = 1; redirect_pc = 32'h203; tick();
        redirect_valid = 0;
        n_checks++;
        if ({pc, misalign_err} !== {32'h200, 1'b1})
            $display("FAIL misalign_apply pc=%h mis=%b exp pc=00000200 mis=1", pc, misalign_err);
        else n_pass++;
        tick();
        n_checks++;
        if ({pc, misalign_err} !== {32'h204, 1'b0})
            $display("FAIL misalign_pulse pc=%h mis=%b exp pc=00000204 mis=0", pc, misalign_err);
        else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        stall = 1; redirect_valid = 1; redirect_pc = 32'h3000; tick();
        redirect_valid = 0;
        reset_n = 0; #2;
        n_checks++;
        if ({pc, pc_valid} !== {32'h0, 1'b0})
            $display("FAIL hold_reset pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1; stall = 0;
        model_reset();
        tick();
        n_checks++;
        if (pc !== 32'h4) $display("FAIL hold_reset_discard pc=%h exp=00000004", pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] words[6];
        for (int n = 0; n < 400; n++) begin
            words[0] = 32'h0;
            words[1] = {6'h02, 26'($urandom)};
            words[2] = {6'h03, 26'($urandom)};
            words[3] = {6'h04, 10'($urandom), 16'($urandom)};
            words[4] = {6'h05, 10'($urandom), 16'($urandom)};
            words[5] = $urandom;
            instr          = words[$urandom_range(0, 5)];
            instr_valid    = ($urandom_range(0, 9) < 8);
            stall          = ($urandom_range(0, 9) < 3);
            halt_req       = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 99) < 15);
            redirect_pc    = $urandom;
            n_checks++;
            if (pc_plus4 !== m_pc + 32'd4)
                $display("FAIL rand_plus4[%0d] got=%h exp=%h", n, pc_plus4, m_pc + 32'd4);
            else n_pass++;
            tick();
            n_checks++;
            if ({pc, pc_valid, halted, pred_taken, misalign_err} !== {m_pc, m_valid, m_halt, m_pred, m_mis})
                $display("FAIL rand_step[%0d] pc=%h v=%b h=%b p=%b m=%b exp pc=%h v=%b h=%b p=%b m=%b",
                         n, pc, pc_valid, halted, pred_taken, misalign_err, m_pc, m_valid, m_halt, m_pred, m_mis);
            else n_pass++;
        end
        redirect_valid = 0; stall = 0; halt_req = 0;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_stall_redirect();
        test_halt();
        test_predict();
        test_wrap_misalign();
        test_reset_in_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
